iob_clint_rearm: RTL
====================

Name: iob_clint_rearm

Overview:
- IOb-native bus initiator that drives the CLINT timer registers from hardware, producing a drift-free periodic tick for one hart without CPU involvement.
- On enable it reads 64-bit mtime, then writes mtimecmp[HART_ID] = mtime + period and waits for that hart's mtip.
- On each tick it re-arms with mtimecmp + period.
- Sits beside the CPU on the interconnect as a second master targeting the CLINT slave.

Parameters:
ADDR_W, 16, IOb address width (CLINT register map: mtimecmp at 0x4000 + 8*hart, mtime at 0xBFF8, low word at +0, high word at +4)
DATA_W, 32, IOb data width; fixed at 32
N_CORES, 1, width of mtip_i
HART_ID, 0, hart whose mtimecmp/mtip is used; must be < N_CORES

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
enable_i  in  1  level; high starts and keeps periodic operation
period_i  in  32  tick period in mtime units; sampled at each arm/re-arm
mtip_i  in  N_CORES  timer-pending lines from CLINT
iob_avalid_o  out  1  request valid
iob_addr_o  out  ADDR_W  byte address
iob_wdata_o  out  DATA_W  write data
iob_wstrb_o  out  DATA_W/8  write strobes; 0 = read, all-ones = write
iob_rvalid_i  in  1  read data valid
iob_rdata_i  in  DATA_W  read data
iob_ready_i  in  1  request accepted
tick_o  out  1  one-cycle pulse per expired period
busy_o  out  1  high whenever the FSM is not IDLE
tick_cnt_o  out  32  ticks since last start, wraps at 2^32
miss_cnt_o  out  8  missed-deadline count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM IDLE; internal cmp register 0.
- Handshake:
  - A request holds avalid/addr/wdata/wstrb stable until the cycle avalid&ready=1. avalid drops the following cycle.
  - Reads: the FSM waits for rvalid_i (≥1 cycle after acceptance) before issuing the next request. Only one outstanding request at a time.
  - Writes: complete on acceptance.
- FSM:
  - IDLE: enable_i=1 → RD_HI1; tick_cnt_o cleared.
  - RD_HI1: read 0xBFFC → hi1.
  - RD_LO: read 0xBFF8 → lo.
  - RD_HI2: read 0xBFFC → hi2. If hi2 != hi1 → RD_LO with hi1 := hi2 (torn-read retry). Else base = {hi1,lo} → CALC.
  - CALC (1 cycle): cmp = base + zero-extended period_i, modulo 2^64. period_i=0 is treated as 1.
  - WR_LO_MAX: write 0xFFFFFFFF to 0x4000+8*HART_ID. This prevents a spurious match during the split update.
  - WR_HI: write cmp[63:32] to +4.
  - WR_LO: write cmp[31:0] to +0.
  - SETTLE (1 cycle): lets the CLINT's registered update reach mtip.
  - ARMED: wait for mtip_i[HART_ID]=1. Then:
    - tick_o=1 for one cycle; tick_cnt_o increments.
    - If enable_i=1: base = cmp → CALC (re-arm from previous deadline, no mtime re-read).
    - Else → IDLE.
- enable_i low:
  - In ARMED → IDLE next cycle; no tick.
  - In any bus state: the current request completes (never withdraw avalid before ready; for reads, wait for rvalid), then → IDLE.
  - mtimecmp is left as written.
- arst_i mid-transaction: immediate return to reset values; avalid drops asynchronously.
- mtip_i is treated as synchronous to clk_i; it is sampled only in SETTLE and ARMED.

Optional Feature:
- Macro: IOB_CLINT_REARM_MISS_EN.
- Defined:
  - In SETTLE, if mtip_i[HART_ID] is already 1, the deadline was missed: miss_cnt_o increments (saturates at 255).
  - The FSM adds period again (→ CALC with base = cmp) without pulsing tick_o, repeating until a future deadline is armed.
- Undefined: miss_cnt_o tied to 0; SETTLE always → ARMED, so a missed deadline yields an immediate tick in ARMED.

Test Plan:
- Slave model with mtime=0x0000_0000_0000_1000, period_i=0x100, enable_i=1:
  - Bus sequence is reads BFFC, BFF8, BFFC.
  - Then writes 0x4000←FFFFFFFF, 0x4004←0, 0x4000←0x1100.
  - busy_o=1 throughout.
- mtime hi changes between RD_HI1 and RD_HI2 (0x0/0xFFFFFFFF → 0x1/0x00000002):
  - RD_LO is retried.
  - Written cmp = 0x1_0000_0102 (period 0x100).
- mtip_i[0] raised after arming:
  - Exactly one tick_o pulse; tick_cnt_o=1.
  - Next writes carry cmp 0x1200 (0x1100+0x100).
- iob_ready_i held low 5 cycles on each request, rvalid delayed 3 cycles:
  - addr/wdata/wstrb stable while avalid=1; no second request before rvalid.
- enable_i dropped mid-WR_HI:
  - WR_HI completes; no WR_LO issued; FSM → IDLE; busy_o=0.
- With IOB_CLINT_REARM_MISS_EN: mtip_i[0] held high during SETTLE for two consecutive re-arms:
  - miss_cnt_o=2; cmp advanced 3×period; no tick_o during misses.

Source files
------------

// File: rtl/iob_clint_rearm.sv
// iob_clint_rearm: IOb bus master that keeps one hart's CLINT mtimecmp re-armed for a drift-free periodic tick.
//
// Optional feature: define IOB_CLINT_REARM_MISS_EN to detect missed deadlines in SETTLE
// (count them and re-arm again without ticking); undefined, miss_cnt_o stays 0.
//
// Ports:
//   clk_i, arst_i        clock, asynchronous active-high reset
//   enable_i             level; high runs periodic operation, low stops after the current bus request
//   period_i             tick period in mtime units, sampled in each CALC (0 behaves as 1)
//   mtip_i               CLINT timer-pending lines; bit HART_ID is used
//   iob_*                IOb initiator port toward the CLINT (wstrb 0 = read, all-ones = write)
//   tick_o               one-cycle pulse per expired period
//   busy_o               high whenever the FSM is not idle
//   tick_cnt_o           ticks since the last start, wrapping
//   miss_cnt_o           missed deadlines since the last start, saturating
module iob_clint_rearm #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1,
    parameter int HART_ID = 0
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                enable_i,
    input  logic [31:0]         period_i,
    input  logic [N_CORES-1:0]  mtip_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i,
    output logic                tick_o,
    output logic                busy_o,
    output logic [31:0]         tick_cnt_o,
    output logic [7:0]          miss_cnt_o
);
    typedef enum logic [3:0] {
        IDLE, RD_HI1, RD_LO, RD_HI2, CALC, WR_LO_MAX, WR_HI, WR_LO, SETTLE, ARMED
    } state_t;

    localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(32'hBFFC);
    localparam logic [ADDR_W-1:0] CMP_LO   = ADDR_W'(32'h4000 + 8 * HART_ID);
    localparam logic [ADDR_W-1:0] CMP_HI   = ADDR_W'(32'h4004 + 8 * HART_ID);

    state_t      state, state_nxt;
    logic        pend, pend_nxt;
    logic [31:0] hi1, hi1_nxt, lo, lo_nxt;
    logic [63:0] cmp, cmp_nxt;
    logic        tick, tick_nxt;
    logic [31:0] tick_cnt, tick_cnt_nxt;
    logic [7:0]  miss_cnt, miss_cnt_nxt;
    logic        is_rd, is_wr, done;
    logic        mtip;
    logic [31:0] per;

    assign mtip       = mtip_i[HART_ID];
    assign per        = (period_i == 32'd0) ? 32'd1 : period_i;
    assign busy_o     = (state != IDLE);
    assign tick_o     = tick;
    assign tick_cnt_o = tick_cnt;
    assign miss_cnt_o = miss_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            pend     <= 1'b0;
            hi1      <= '0;
            lo       <= '0;
            cmp      <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            hi1      <= hi1_nxt;
            lo       <= lo_nxt;
            cmp      <= cmp_nxt;
            tick     <= tick_nxt;
            tick_cnt <= tick_cnt_nxt;
            miss_cnt <= miss_cnt_nxt;
        end
    end

    // pend marks an accepted request: a read then waits for rvalid, a write
    // spends one gap cycle so avalid drops between back-to-back writes.
    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        hi1_nxt      = hi1;
        lo_nxt       = lo;
        cmp_nxt      = cmp;
        tick_nxt     = 1'b0;
        tick_cnt_nxt = tick_cnt;
        miss_cnt_nxt = miss_cnt;
        is_rd        = state inside {RD_HI1, RD_LO, RD_HI2};
        is_wr        = state inside {WR_LO_MAX, WR_HI, WR_LO};
        done         = pend && (is_wr || iob_rvalid_i);
        iob_avalid_o = (is_rd || is_wr) && !pend;
        iob_addr_o   = (state inside {RD_HI1, RD_HI2}) ? MTIME_HI :
                       (state == RD_LO)                ? MTIME_LO :
                       (state == WR_HI)                ? CMP_HI   :
                       is_wr                           ? CMP_LO   : '0;
        iob_wdata_o  = (state == WR_LO_MAX) ? {DATA_W{1'b1}} :
                       (state == WR_HI)     ? cmp[63:32]     :
                       (state == WR_LO)     ? cmp[31:0]      : '0;
        iob_wstrb_o  = is_wr ? {(DATA_W/8){1'b1}} : '0;
        if (iob_avalid_o && iob_ready_i) pend_nxt = 1'b1;
        if (done) pend_nxt = 1'b0;
        case (state)
            IDLE: if (enable_i) begin
                state_nxt    = RD_HI1;
                tick_cnt_nxt = '0;
                miss_cnt_nxt = '0;
            end
            RD_HI1: if (done) begin
                hi1_nxt   = iob_rdata_i;
                state_nxt = enable_i ? RD_LO : IDLE;
            end
            RD_LO: if (done) begin
                lo_nxt    = iob_rdata_i;
                state_nxt = enable_i ? RD_HI2 : IDLE;
            end
            // A changed high word means lo may belong to either epoch; re-read lo
            // against the newer high word.
            RD_HI2: if (done) begin
                hi1_nxt   = iob_rdata_i;
                cmp_nxt   = {hi1, lo};
                state_nxt = !enable_i ? IDLE : (iob_rdata_i != hi1) ? RD_LO : CALC;
            end
            CALC: begin
                cmp_nxt   = cmp + {32'd0, per};
                state_nxt = enable_i ? WR_LO_MAX : IDLE;
            end
            WR_LO_MAX: if (done) state_nxt = enable_i ? WR_HI : IDLE;
            WR_HI:     if (done) state_nxt = enable_i ? WR_LO : IDLE;
            WR_LO:     if (done) state_nxt = enable_i ? SETTLE : IDLE;
            SETTLE: begin
`ifdef IOB_CLINT_REARM_MISS_EN
                if (mtip) begin
                    miss_cnt_nxt = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
                    state_nxt    = CALC;
                end else begin
                    state_nxt = ARMED;
                end
`else
                state_nxt = ARMED;
`endif
            end
            ARMED: begin
                if (!enable_i) begin
                    state_nxt = IDLE;
                end else if (mtip) begin
                    tick_nxt     = 1'b1;
                    tick_cnt_nxt = tick_cnt + 32'd1;
                    state_nxt    = CALC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
